// File: rtl/sd_pio_pkg.sv
// Shared constants for the SD DAT input port: register word addresses,
// edge-type selectors and the Avalon data width.
package sd_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sd_dat_in_pio_if.sv
// Avalon-MM slave bus of the SD DAT input port, plus its interrupt line.
interface sd_dat_in_pio_if;
    import sd_pio_pkg::*;

    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/sd_pio_sync_edge.sv
// Three-stage synchroniser for the DAT lines, a priming counter that
// suppresses edges caused by the reset values of the chain, and the
// per-bit edge term selected by EDGE_TYPE.
module sd_pio_sync_edge
    import sd_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = EDGE_FALL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [1:0]       r_prime_cnt;
    logic             w_primed;

    // Synchroniser chain; s2 is the usable level, s3 its one-cycle history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Priming counter: saturates at 3 once the chain holds real samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prime_cnt <= 2'd0;
        end else if (r_prime_cnt != 2'd3) begin
            r_prime_cnt <= r_prime_cnt + 2'd1;
        end
    end

    assign w_primed = (r_prime_cnt == 2'd3);
    assign o_level  = r_s2;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            logic w_rise;
            logic w_fall;
            logic w_sel;

            assign w_rise = r_s2[gi] & ~r_s3[gi];
            assign w_fall = ~r_s2[gi] & r_s3[gi];

            if (EDGE_TYPE == EDGE_RISE) begin : g_rise
                assign w_sel = w_rise;
            end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
                assign w_sel = w_fall;
            end else begin : g_any
                assign w_sel = w_rise | w_fall;
            end

            assign o_edge[gi] = w_sel & w_primed;
        end
    endgenerate

endmodule

// File: rtl/sd_dat_in_pio.sv
// SD DAT input port for the software SD driver: synchronised level read,
// interrupt mask, software-clearable edge capture and a level irq.
// Optional build macro SD_DAT_IN_BIT_CLEAR_EN: when defined, a write to the
// capture register clears only the bits written 1; otherwise any write to it
// clears every capture bit. A new edge always wins over a clear.
module sd_dat_in_pio
    import sd_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = EDGE_FALL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    sd_dat_in_pio_if.slave   bus
);

    logic [WIDTH-1:0]  w_level;
    logic [WIDTH-1:0]  w_edge;
    logic [WIDTH-1:0]  w_clear;
    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  r_capture;
    logic [DATA_W-1:0] w_rd_mux;
    logic [DATA_W-1:0] r_readdata;
    logic              w_wr;
    logic              w_unused_wdata;

    sd_pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_in    (in_port),
        .o_level (w_level),
        .o_edge  (w_edge)
    );

    assign w_wr = bus.chipselect & ~bus.write_n;

    // Bits above WIDTH carry no meaning; fold them so they are not dangling.
    assign w_unused_wdata = ^bus.writedata;

    // Capture-clear request for this cycle.
    always_comb begin
        w_clear = '0;
        if (w_wr && (bus.address == ADDR_CAPTURE)) begin
`ifdef SD_DAT_IN_BIT_CLEAR_EN
            w_clear = bus.writedata[WIDTH-1:0];
`else
            w_clear = '1;
`endif
        end
    end

    // Interrupt mask register, written at address 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_wr && (bus.address == ADDR_MASK)) begin
            r_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Edge capture: clear first, then OR in new edges so none is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_capture <= '0;
        end else begin
            r_capture <= (r_capture & ~w_clear) | w_edge;
        end
    end

    // Read mux; unused upper bits and the reserved word read as zero.
    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_level;
            ADDR_MASK:    w_rd_mux[WIDTH-1:0] = r_mask;
            ADDR_CAPTURE: w_rd_mux[WIDTH-1:0] = r_capture;
            default:      w_rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle, giving a fixed latency of one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_capture & r_mask);

endmodule

// File: tb/tb_sd_dat_in_pio.sv
// Self-checking bench for sd_dat_in_pio: directed steps followed by random
// traffic, all checked against a cycle-indexed reference model.
module tb_sd_dat_in_pio;
    import sd_pio_pkg::*;

    localparam int EDGE = EDGE_FALL;

`ifdef SD_DAT_IN_BIT_CLEAR_EN
    localparam bit BIT_CLR = 1'b1;
`else
    localparam bit BIT_CLR = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;

    sd_dat_in_pio_if bus ();

    sd_dat_in_pio #(
        .WIDTH     (4),
        .EDGE_TYPE (EDGE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: lv_q[n-1] is the input value present at the n-th
    // clock edge after reset release. A level becomes readable two edges
    // after it is sampled and an edge is captured one edge later still.
    logic [3:0]  lv_q[$];
    int          m_k;
    logic [3:0]  m_mask;
    logic [3:0]  m_cap;
    logic [31:0] m_rd;

    function automatic logic [3:0] level_at(input int n);
        if (n < 1 || n > lv_q.size()) return 4'h0;
        return lv_q[n-1];
    endfunction

    task automatic model_reset();
        lv_q.delete();
        m_k    = 0;
        m_mask = 4'h0;
        m_cap  = 4'h0;
        m_rd   = 32'h0;
    endtask

    task automatic model_edge();
        logic [3:0]  now_l, prev_l, ev, clr;
        logic [31:0] rd;
        m_k++;
        now_l  = level_at(m_k - 2);
        prev_l = level_at(m_k - 3);
        case (EDGE)
            EDGE_RISE: ev = now_l & ~prev_l;
            EDGE_FALL: ev = ~now_l & prev_l;
            default:   ev = now_l ^ prev_l;
        endcase
        if (m_k - 1 < 3) ev = 4'h0;
        rd = 32'h0;
        case (bus.address)
            2'd0:    rd[3:0] = now_l;
            2'd2:    rd[3:0] = m_mask;
            2'd3:    rd[3:0] = m_cap;
            default: rd = 32'h0;
        endcase
        clr = 4'h0;
        if (bus.chipselect && !bus.write_n) begin
            if (bus.address == 2'd2) m_mask = bus.writedata[3:0];
            if (bus.address == 2'd3) clr = BIT_CLR ? bus.writedata[3:0] : 4'hF;
        end
        m_cap = (m_cap & ~clr) | ev;
        m_rd  = rd;
        lv_q.push_back(in_port);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model at the edge, then compare just after it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("readdata", bus.readdata, m_rd);
        chk("irq", {31'h0, bus.irq}, {31'h0, |(m_cap & m_mask)});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.address = a;
        tick();
        chk(tag, bus.readdata, exp);
        $display("read  addr=%0d data=%h", a, bus.readdata);
    endtask

    // Reset pulse asserted between edges; irq must drop without a clock.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_irq_async", {31'h0, bus.irq}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        in_port        = 4'hF;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Steady inputs through reset never create capture bits.
        bus.address = 2'd3;
        repeat (9) tick();
        rd(2'd3, 32'h0, "cap_after_reset");
        chk("irq_after_reset", {31'h0, bus.irq}, 32'h0);
        rd(2'd0, 32'h0000000F, "level_after_reset");

        // Falling edge on bit 0: irq exactly three edges after the change.
        wr(2'd2, 32'h1);
        in_port = 4'hE;
        tick();
        tick();
        chk("irq_edge2", {31'h0, bus.irq}, 32'h0);
        tick();
        chk("irq_edge3", {31'h0, bus.irq}, 32'h1);
        rd(2'd3, 32'h1, "cap_fall_bit0");

        // Rising edge adds nothing under falling-edge capture.
        in_port = 4'hF;
        repeat (4) tick();
        rd(2'd3, 32'h1, "cap_no_rise");

        // Masking: capture 6 with mask 1 is quiet, mask 4 raises irq.
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 4'h9;
        repeat (4) tick();
        wr(2'd2, 32'h1);
        chk("irq_masked", {31'h0, bus.irq}, 32'h0);
        wr(2'd2, 32'h4);
        chk("irq_unmasked", {31'h0, bus.irq}, 32'h1);
        rd(2'd3, 32'h6, "cap_six");
        rd(2'd2, 32'h4, "mask_rb");
        rd(2'd1, 32'h0, "reserved");

        // Clear by writing 2 to the capture register.
        wr(2'd3, 32'h2);
        rd(2'd3, BIT_CLR ? 32'h4 : 32'h0, "cap_clear");

        // Edge arriving in the same cycle as a clear-all is kept.
        wr(2'd2, 32'h1);
        wr(2'd3, 32'hF);
        in_port = 4'h8;
        tick();
        tick();
        wr(2'd3, 32'hF);
        chk("irq_set_over_clr", {31'h0, bus.irq}, 32'h1);
        rd(2'd3, 32'h1, "cap_set_over_clr");

        // Reset mid-operation with everything captured and unmasked.
        in_port = 4'hF;
        repeat (4) tick();
        in_port = 4'h0;
        repeat (4) tick();
        wr(2'd2, 32'hF);
        rd(2'd3, 32'hF, "cap_all");
        chk("irq_all", {31'h0, bus.irq}, 32'h1);
        do_reset();
        in_port = 4'hF;
        rd(2'd2, 32'h0, "mask_post_rst");
        in_port = 4'h0;
        rd(2'd3, 32'h0, "cap_post_rst1");
        rd(2'd3, 32'h0, "cap_post_rst2");
        repeat (6) tick();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                $display("random reset at step %0d", i);
            end
            if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
            bus.address    = 2'($urandom);
            bus.chipselect = ($urandom_range(0, 2) == 0);
            bus.write_n    = ($urandom_range(0, 1) == 0);
            bus.writedata  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
